vote_frame_controller: RTL and testbench
========================================

Name: vote_frame_controller

Overview:
Sequences the UART receive byte stream into framed vote packets and hands validated votes to vote_processor. Parses each frame (sync, voter ID, candidate, checksum) and checks candidate range and checksum. Enforces an inter-byte timeout, holds each accepted vote under a valid/ready handshake, and keeps saturating good/bad/dropped statistics for the election controller.

Parameters:
ID_BYTES, 2, number of voter-ID bytes per frame (1..4); the first byte received is the MS byte
NUM_CANDIDATES, 2, legal candidate codes are 0..NUM_CANDIDATES-1
TIMEOUT_CYCLES, 50_000, maximum clk_in cycles between bytes inside a frame
CNT_W, 16, width of the statistics counters

Ports:
clk_in  input  1  system clock; all logic is synchronous to it
rst_in  input  1  asynchronous, active-low reset
enable_in  input  1  election open; when low, no new frame starts
new_data_in  input  1  one-cycle strobe from uart_receive
data_byte_in  input  8  received byte, valid while new_data_in is high
vote_ready_in  input  1  vote_processor can accept a vote (inverse of its stall)
vote_valid_out  output  1  a validated vote is presented
candidate_out  output  8  candidate code of the presented vote
voter_id_out  output  8*ID_BYTES  voter ID of the presented vote
busy_out  output  1  FSM is not in IDLE
frame_err_out  output  1  one-cycle pulse on any rejected frame
good_count_out  output  CNT_W  number of accepted frames
bad_count_out  output  CNT_W  number of rejected frames
drop_count_out  output  CNT_W  number of bytes discarded while a vote is presented

Behaviour:
- Reset (rst_in low, asynchronous): every output is 0, FSM goes to IDLE, and all counters and shift registers clear. This applies mid-frame or mid-handshake; a partial frame is discarded without being counted.
- Frame format: SYNC_BYTE (0xA5), ID_BYTES ID bytes, CAND byte, CSUM byte. CSUM = XOR of all ID bytes and CAND.
- FSM states: IDLE, ID, CAND, CSUM, PRESENT.
- IDLE:
  - Takes a byte only when new_data_in and enable_in are both high.
  - 0xA5 moves the FSM to ID, clears the byte index and clears the running XOR.
  - Any other byte is ignored and not counted (line noise).
- ID:
  - Shifts the byte into the ID register and XORs it into the running checksum.
  - After ID_BYTES bytes, moves to CAND.
- CAND: latches the candidate, XORs it in, moves to CSUM.
- CSUM: compares the byte with the running XOR and checks CAND < NUM_CANDIDATES.
  - Both pass: PRESENT is entered and vote_valid_out rises on the cycle after the CSUM strobe (latency 1). good_count increments.
  - Either fails: IDLE is entered, frame_err_out pulses for 1 cycle, bad_count increments.
- PRESENT:
  - vote_valid_out, candidate_out and voter_id_out stay stable until vote_valid_out and vote_ready_in are high in the same cycle.
  - On that transfer cycle the FSM returns to IDLE; vote_valid_out is low the following cycle.
  - Bytes arriving in PRESENT are discarded and drop_count increments, including a 0xA5 byte.
  - enable_in falling during PRESENT does not cancel the vote.
- Timeout:
  - An inter-byte counter runs in ID, CAND and CSUM and reloads on every new_data_in.
  - Reaching TIMEOUT_CYCLES sends the FSM to IDLE with an frame_err_out pulse and a bad_count increment.
  - If a byte strobe coincides with expiry, the byte wins and the timer reloads.
  - The timer is idle in IDLE and PRESENT.
- enable_in falling in ID, CAND or CSUM aborts the frame to IDLE; the abort is not counted and produces no error pulse.
- A byte arriving on the same cycle as the handshake transfer is processed as IDLE input, so a 0xA5 there starts a new frame.
- All counters saturate at 2^CNT_W-1 and never wrap.
- busy_out = (state != IDLE).

Decomposition:
- Package vote_pkg holds:
  - SYNC_BYTE = 8'hA5
  - the frame_state_t enum {IDLE, ID, CAND, CSUM, PRESENT}
  - the CAND_W = 8 constant
  - a sat_inc function for the saturating counters
- One sub-module, interbyte_timer: ports clear (reload), run, and expired; parameter TIMEOUT_CYCLES.

Test Plan:
- Valid frame: bytes A5 12 34 01 27, vote_ready_in held high -> vote_valid_out high for 1 cycle, candidate_out=0x01, voter_id_out=0x1234, good_count=1, bad_count=0.
- Bad checksum: A5 12 34 01 28 -> no vote_valid_out, frame_err_out one pulse, bad_count=1. Then noise 00 FF followed by a valid frame -> accepted, good_count=1.
- Candidate out of range (NUM_CANDIDATES=2): A5 00 05 02 07 -> rejected, bad_count=1, vote_valid_out stays 0.
- Back-pressure: valid frame, then vote_ready_in low for 40000 cycles while 3 bytes arrive -> outputs stable, drop_count=3. Raising vote_ready_in -> exactly one transfer.
- Timeout: A5 12 then silence for TIMEOUT_CYCLES -> return to IDLE, bad_count=1, frame_err_out pulse. The next valid frame is accepted. A byte landing exactly at expiry is accepted instead.
- Reset mid-frame: A5 12, then rst_in low for 3 cycles asynchronously -> all outputs and counters are 0 immediately. A following valid frame gives good_count=1.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared types and helpers for the vote frame controller.
package vote_pkg;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam int unsigned CAND_W    = 8;

  typedef enum logic [2:0] {IDLE, ID, CAND, CSUM, PRESENT} frame_state_t;

  // Counters up to 32 bits wide share this helper through zero-extension.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value >= max_value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/interbyte_timer.sv
// Inter-byte gap timer: expires when TIMEOUT_CYCLES cycles pass with no reload while running.
module interbyte_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (clear || !run) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter holds cycles elapsed since the last strobe minus one, so LAST marks the Nth cycle.
  assign expired = run && (cnt_q == LAST);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vote_frame_controller.sv
// Parses UART bytes into sync/ID/candidate/checksum frames and presents validated votes.
module vote_frame_controller
  import vote_pkg::*;
#(
  parameter int unsigned ID_BYTES       = 2,
  parameter int unsigned NUM_CANDIDATES = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50_000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  enable_in,
  input  logic                  new_data_in,
  input  logic [7:0]            data_byte_in,
  input  logic                  vote_ready_in,
  output logic                  vote_valid_out,
  output logic [CAND_W-1:0]     candidate_out,
  output logic [8*ID_BYTES-1:0] voter_id_out,
  output logic                  busy_out,
  output logic                  frame_err_out,
  output logic [CNT_W-1:0]      good_count_out,
  output logic [CNT_W-1:0]      bad_count_out,
  output logic [CNT_W-1:0]      drop_count_out
);

  localparam int unsigned ID_W     = 8 * ID_BYTES;
  localparam logic [2:0]  LAST_IDX = 3'(ID_BYTES - 1);
  localparam logic [31:0] CNT_MAX  = 32'((64'd1 << CNT_W) - 64'd1);

  frame_state_t      state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        xor_q, xor_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [CAND_W-1:0] cand_q, cand_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  good_q, good_d;
  logic [CNT_W-1:0]  bad_q, bad_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic [ID_W+7:0] id_shift;
  logic            start_frame;
  logic            in_frame;
  logic            cand_ok;
  logic            tmr_expired;

  assign id_shift    = {id_q, data_byte_in};
  assign start_frame = new_data_in && enable_in && (data_byte_in == SYNC_BYTE);
  assign in_frame    = (state_q == ID) || (state_q == CAND) || (state_q == CSUM);
  assign cand_ok     = 32'(cand_q) < NUM_CANDIDATES;

  interbyte_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clear  (new_data_in),
    .run    (in_frame),
    .expired(tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    xor_d   = xor_q;
    id_d    = id_q;
    cand_d  = cand_q;
    good_d  = good_q;
    bad_d   = bad_q;
    drop_d  = drop_q;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_frame) begin
          state_d = ID;
          idx_d   = '0;
          xor_d   = '0;
        end
      end
      ID, CAND, CSUM: begin
        // Disable wins over everything, then a byte, then expiry.
        if (!enable_in) begin
          state_d = IDLE;
        end else if (new_data_in) begin
          case (state_q)
            ID: begin
              id_d  = id_shift[ID_W-1:0];
              xor_d = xor_q ^ data_byte_in;
              idx_d = idx_q + 3'd1;
              if (idx_q == LAST_IDX) state_d = CAND;
            end
            CAND: begin
              cand_d  = data_byte_in;
              xor_d   = xor_q ^ data_byte_in;
              state_d = CSUM;
            end
            default: begin
              if ((data_byte_in == xor_q) && cand_ok) begin
                state_d = PRESENT;
                good_d  = CNT_W'(sat_inc(32'(good_q), CNT_MAX));
              end else begin
                state_d = IDLE;
                err_d   = 1'b1;
                bad_d   = CNT_W'(sat_inc(32'(bad_q), CNT_MAX));
              end
            end
          endcase
        end else if (tmr_expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
          bad_d   = CNT_W'(sat_inc(32'(bad_q), CNT_MAX));
        end
      end
      PRESENT: begin
        // A byte on the transfer cycle is treated as IDLE input.
        if (valid_q && vote_ready_in) begin
          state_d = IDLE;
          if (start_frame) begin
            state_d = ID;
            idx_d   = '0;
            xor_d   = '0;
          end
        end else if (new_data_in) begin
          drop_d = CNT_W'(sat_inc(32'(drop_q), CNT_MAX));
        end
      end
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == PRESENT);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      idx_q   <= '0;
      xor_q   <= '0;
      id_q    <= '0;
      cand_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      good_q  <= '0;
      bad_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      xor_q   <= xor_d;
      id_q    <= id_d;
      cand_q  <= cand_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      drop_q  <= drop_d;
    end
  end

  assign vote_valid_out = valid_q;
  assign candidate_out  = cand_q;
  assign voter_id_out   = id_q;
  assign busy_out       = busy_q;
  assign frame_err_out  = err_q;
  assign good_count_out = good_q;
  assign bad_count_out  = bad_q;
  assign drop_count_out = drop_q;

endmodule

// File: tb/tb_vote_frame_controller.sv
// Scenario bench for vote_frame_controller with a frame-level reference model.
module tb_vote_frame_controller;

  localparam int unsigned ID_BYTES = 2;
  localparam int unsigned NUM_CAND = 2;
  localparam int unsigned TMO      = 300;
  localparam int unsigned CNT_W    = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        new_data = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        ready = 1'b0;

  logic        valid, busy, err;
  logic [7:0]  cand;
  logic [15:0] id;
  logic [15:0] good, bad, drop;

  logic        s_valid, s_busy, s_err;
  logic [7:0]  s_cand;
  logic [15:0] s_id;
  logic [1:0]  s_good, s_bad, s_drop;

  int checks = 0;
  int errors = 0;
  int exp_good = 0;
  int exp_bad = 0;
  int exp_drop = 0;
  int xfers;

  vote_frame_controller #(
    .ID_BYTES(ID_BYTES), .NUM_CANDIDATES(NUM_CAND), .TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)
  ) dut (
    .clk_in(clk), .rst_in(rst_n), .enable_in(enable), .new_data_in(new_data),
    .data_byte_in(data), .vote_ready_in(ready), .vote_valid_out(valid),
    .candidate_out(cand), .voter_id_out(id), .busy_out(busy), .frame_err_out(err),
    .good_count_out(good), .bad_count_out(bad), .drop_count_out(drop)
  );

  // Narrow-counter twin driven identically, used to observe saturation.
  vote_frame_controller #(
    .ID_BYTES(ID_BYTES), .NUM_CANDIDATES(NUM_CAND), .TIMEOUT_CYCLES(TMO), .CNT_W(2)
  ) dut_sat (
    .clk_in(clk), .rst_in(rst_n), .enable_in(enable), .new_data_in(new_data),
    .data_byte_in(data), .vote_ready_in(ready), .vote_valid_out(s_valid),
    .candidate_out(s_cand), .voter_id_out(s_id), .busy_out(s_busy), .frame_err_out(s_err),
    .good_count_out(s_good), .bad_count_out(s_bad), .drop_count_out(s_drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) xfers <= 0;
    else if (valid && ready) xfers <= xfers + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] csum_of(input logic [15:0] vid, input logic [7:0] c);
    return vid[15:8] ^ vid[7:0] ^ c;
  endfunction

  function automatic bit frame_ok(input logic [15:0] vid, input logic [7:0] c,
                                  input logic [7:0] s);
    return (s == csum_of(vid, c)) && (int'(c) < NUM_CAND);
  endfunction

  // Strobe lands `gap` clocks after the previous strobe; returns 1 time unit after that edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap - 1) @(posedge clk);
    #1 new_data = 1'b1;
    data = b;
    @(posedge clk);
    #1 new_data = 1'b0;
    data = 8'($urandom);
  endtask

  // Sends a whole frame (ready assumed high) and checks the verdict cycle and the one after.
  task automatic run_frame(input string name, input logic [15:0] vid, input logic [7:0] c,
                           input logic [7:0] s, input int gap);
    bit ok;
    ok = frame_ok(vid, c, s);
    send_byte(8'hA5, gap);
    send_byte(vid[15:8], gap);
    send_byte(vid[7:0], gap);
    send_byte(c, gap);
    send_byte(s, gap);
    if (ok) exp_good++;
    else exp_bad++;
    checks++;
    if (valid !== ok || err !== !ok) begin
      errors++;
      $display("FAIL %s verdict valid=%0b err=%0b expected valid=%0b err=%0b",
               name, valid, err, ok, !ok);
    end
    if (ok) begin
      checks++;
      if (cand !== c || id !== vid) begin
        errors++;
        $display("FAIL %s payload cand=%h id=%h expected cand=%h id=%h", name, cand, id, c, vid);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (valid !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s after valid=%0b err=%0b expected 0 0", name, valid, err);
    end
    checks++;
    if (good !== 16'(exp_good) || bad !== 16'(exp_bad)) begin
      errors++;
      $display("FAIL %s counts good=%0d bad=%0d expected %0d %0d",
               name, good, bad, exp_good, exp_bad);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({valid, busy, err, cand, id, good, bad, drop} !== '0) begin
      errors++;
      $display("FAIL reset outputs got %h expected 0", {valid, busy, err, cand, id, good, bad, drop});
    end
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
    ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_valid_frame();
    run_frame("valid_frame", 16'h1234, 8'h01, 8'h27, 1);
    run_frame("valid_gap", 16'hBEEF, 8'h00, csum_of(16'hBEEF, 8'h00), 7);
  endtask

  task automatic test_bad_checksum();
    run_frame("bad_csum", 16'h1234, 8'h01, 8'h28, 1);
    send_byte(8'h00, 2);
    send_byte(8'hFF, 2);
    checks++;
    if (busy !== 1'b0 || bad !== 16'(exp_bad)) begin
      errors++;
      $display("FAIL noise busy=%0b bad=%0d expected 0 %0d", busy, bad, exp_bad);
    end
    run_frame("after_noise", 16'h1234, 8'h01, 8'h27, 1);
  endtask

  task automatic test_cand_range();
    run_frame("cand_range", 16'h0005, 8'h02, 8'h07, 1);
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'hA5, 1);
    send_byte(8'h12, 1);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({valid, busy, err, cand, id, good, bad, drop} !== '0) begin
      errors++;
      $display("FAIL reset_mid got %h expected 0", {valid, busy, err, cand, id, good, bad, drop});
    end
    exp_good = 0;
    exp_bad = 0;
    exp_drop = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run_frame("post_reset", 16'h1234, 8'h01, 8'h27, 1);
  endtask

  task automatic test_timeout();
    send_byte(8'hA5, 1);
    send_byte(8'h12, 1);
    repeat (TMO - 1) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early busy=%0b err=%0b expected 1 0", busy, err);
    end
    @(posedge clk);
    #1;
    exp_bad++;
    checks++;
    if (busy !== 1'b0 || err !== 1'b1 || bad !== 16'(exp_bad)) begin
      errors++;
      $display("FAIL timeout busy=%0b err=%0b bad=%0d expected 0 1 %0d", busy, err, bad, exp_bad);
    end
    run_frame("after_timeout", 16'h1234, 8'h01, 8'h27, 1);
    send_byte(8'hA5, 1);
    send_byte(8'h12, 1);
    send_byte(8'h34, TMO);
    checks++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL at_expiry busy=%0b err=%0b expected 1 0", busy, err);
    end
    send_byte(8'h01, 1);
    send_byte(8'h27, 1);
    exp_good++;
    checks++;
    if (valid !== 1'b1 || good !== 16'(exp_good) || bad !== 16'(exp_bad)) begin
      errors++;
      $display("FAIL at_expiry_vote valid=%0b good=%0d bad=%0d expected 1 %0d %0d",
               valid, good, bad, exp_good, exp_bad);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_pressure();
    int x0;
    logic [7:0] junk [3];
    junk[0] = 8'h00;
    junk[1] = 8'hA5;
    junk[2] = 8'h33;
    ready = 1'b0;
    send_byte(8'hA5, 1);
    send_byte(8'h12, 1);
    send_byte(8'h34, 1);
    send_byte(8'h01, 1);
    send_byte(8'h27, 1);
    exp_good++;
    x0 = xfers;
    for (int i = 0; i < 3; i++) begin
      send_byte(junk[i], 150);
      exp_drop++;
      checks++;
      if (valid !== 1'b1 || cand !== 8'h01 || id !== 16'h1234 || busy !== 1'b1 || err !== 1'b0)
      begin
        errors++;
        $display("FAIL hold[%0d] valid=%0b cand=%h id=%h busy=%0b err=%0b", i, valid, cand, id,
                 busy, err);
      end
    end
    checks++;
    if (drop !== 16'(exp_drop) || good !== 16'(exp_good)) begin
      errors++;
      $display("FAIL bp_counts drop=%0d good=%0d expected %0d %0d", drop, good, exp_drop, exp_good);
    end
    ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release valid=%0b expected 0", valid);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (xfers - x0 !== 1) begin
      errors++;
      $display("FAIL bp_xfers got %0d expected 1", xfers - x0);
    end
  endtask

  task automatic test_transfer_byte();
    ready = 1'b0;
    send_byte(8'hA5, 1);
    send_byte(8'hBE, 1);
    send_byte(8'hEF, 1);
    send_byte(8'h00, 1);
    send_byte(csum_of(16'hBEEF, 8'h00), 1);
    exp_good++;
    send_byte(8'h55, 3);
    exp_drop++;
    ready = 1'b1;
    new_data = 1'b1;
    data = 8'hA5;
    @(posedge clk);
    #1 new_data = 1'b0;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b1 || drop !== 16'(exp_drop)) begin
      errors++;
      $display("FAIL xfer_byte valid=%0b busy=%0b drop=%0d expected 0 1 %0d",
               valid, busy, drop, exp_drop);
    end
    send_byte(8'h12, 1);
    send_byte(8'h34, 1);
    send_byte(8'h01, 1);
    send_byte(8'h27, 1);
    exp_good++;
    checks++;
    if (valid !== 1'b1 || id !== 16'h1234 || good !== 16'(exp_good)) begin
      errors++;
      $display("FAIL xfer_frame valid=%0b id=%h good=%0d expected 1 1234 %0d",
               valid, id, good, exp_good);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_enable_abort();
    send_byte(8'hA5, 1);
    send_byte(8'h12, 1);
    enable = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || err !== 1'b0 || bad !== 16'(exp_bad)) begin
      errors++;
      $display("FAIL abort busy=%0b err=%0b bad=%0d expected 0 0 %0d", busy, err, bad, exp_bad);
    end
    send_byte(8'hA5, 2);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL disabled_sync busy=%0b expected 0", busy);
    end
    enable = 1'b1;
  endtask

  task automatic test_random();
    logic [15:0] vid;
    logic [7:0]  c, s, noise;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        noise = 8'($urandom);
        if (noise == 8'hA5) noise = 8'h5A;
        send_byte(noise, int'($urandom_range(1, 6)));
      end
      vid = 16'($urandom);
      c = 8'($urandom_range(0, 3));
      s = csum_of(vid, c);
      if ($urandom_range(0, 3) == 0) s = s ^ 8'($urandom_range(1, 255));
      run_frame("random", vid, c, s, int'($urandom_range(1, 9)));
    end
  endtask

  task automatic test_saturation();
    int eg, eb, ed;
    eg = (exp_good > 3) ? 3 : exp_good;
    eb = (exp_bad > 3) ? 3 : exp_bad;
    ed = (exp_drop > 3) ? 3 : exp_drop;
    checks++;
    if (s_good !== 2'(eg) || s_bad !== 2'(eb) || s_drop !== 2'(ed)) begin
      errors++;
      $display("FAIL saturate got %0d %0d %0d expected %0d %0d %0d",
               s_good, s_bad, s_drop, eg, eb, ed);
    end
    checks++;
    if (good !== 16'(exp_good) || bad !== 16'(exp_bad) || drop !== 16'(exp_drop)) begin
      errors++;
      $display("FAIL final_counts got %0d %0d %0d expected %0d %0d %0d",
               good, bad, drop, exp_good, exp_bad, exp_drop);
    end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_bad_checksum();
    test_cand_range();
    test_reset_mid_frame();
    test_timeout();
    test_back_pressure();
    test_transfer_byte();
    test_enable_abort();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
